// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data ports onto one shared memory bus with a single
// outstanding transaction, data-port priority and starvation relief for fetch.
//
// state | meaning
// IDLE  | no transaction; ready goes combinationally to the granted requester
// REQ   | bus_req_valid_o high, registered request held until bus_req_ready_i
// RSP   | waiting for bus_rsp_valid_i; owner's rsp_valid pulses on arrival
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int INST_W     = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    input  logic                if_flush_i,
    output logic                if_req_ready_o,
    output logic                if_rsp_valid_o,
    output logic [INST_W-1:0]   if_rsp_data_o,
    input  logic                mem_req_valid_i,
    input  logic                mem_wen_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    input  logic [DATA_W/8-1:0] mem_wstrb_i,
    output logic                mem_req_ready_o,
    output logic                mem_rsp_valid_o,
    output logic [DATA_W-1:0]   mem_rsp_data_o,
    output logic                bus_req_valid_o,
    input  logic                bus_req_ready_i,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic                bus_wen_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    output logic [DATA_W/8-1:0] bus_wstrb_o,
    input  logic                bus_rsp_valid_i,
    input  logic [DATA_W-1:0]   bus_rsp_data_i,
    output logic                stall_if_o,
    output logic                stall_mem_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(MAX_STARVE + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MAX_STARVE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic                owner_mem_q, owner_mem_d;
    logic                drop_q, drop_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;

    logic                in_idle;
    logic                grant_mem;
    logic                grant_if;
    logic                if_acc;
    logic                mem_acc;
    logic                if_pending;
    logic                mem_pending;
    logic                rsp_fire;
    logic [2*INST_W-1:0] rsp_words;

    always_comb begin
        in_idle   = (state_q == ST_IDLE);
        grant_mem = in_idle && mem_req_valid_i && (starve_cnt_q < STARVE_MAX);
        grant_if  = in_idle && !grant_mem && if_req_valid_i;

        if_req_ready_o  = !rst && grant_if && !if_flush_i;
        mem_req_ready_o = !rst && grant_mem;
        if_acc          = if_req_valid_i && if_req_ready_o;
        mem_acc         = mem_req_valid_i && mem_req_ready_o;

        if_pending  = !in_idle && !owner_mem_q;
        mem_pending = !in_idle && owner_mem_q;
        stall_if_o  = !rst && if_req_valid_i && (!if_acc || if_pending);
        stall_mem_o = !rst && mem_req_valid_i && (!mem_acc || mem_pending);

        bus_req_valid_o = !rst && (state_q == ST_REQ);
        bus_addr_o      = addr_q;
        bus_wen_o       = wen_q;
        bus_wdata_o     = wdata_q;
        bus_wstrb_o     = wstrb_q;

        // A flush arriving on the response cycle itself also kills that response.
        rsp_fire        = !rst && (state_q == ST_RSP) && bus_rsp_valid_i;
        mem_rsp_valid_o = rsp_fire && owner_mem_q;
        if_rsp_valid_o  = rsp_fire && !owner_mem_q && !drop_q && !if_flush_i;

        mem_rsp_data_o = bus_rsp_data_i;
        rsp_words      = (2*INST_W)'(bus_rsp_data_i);
        if_rsp_data_o  = addr_q[2] ? rsp_words[2*INST_W-1:INST_W] : rsp_words[INST_W-1:0];
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        owner_mem_d  = owner_mem_q;
        drop_d       = drop_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_if) begin
                    starve_cnt_d = '0;
                end else if (grant_mem && if_req_valid_i && (starve_cnt_q < STARVE_MAX)) begin
                    starve_cnt_d = starve_cnt_q + 1'b1;
                end
                if (mem_acc) begin
                    state_d     = ST_REQ;
                    owner_mem_d = 1'b1;
                    addr_d      = mem_addr_i;
                    wen_d       = mem_wen_i;
                    wdata_d     = mem_wdata_i;
                    wstrb_d     = mem_wstrb_i;
                end else if (if_acc) begin
                    state_d     = ST_REQ;
                    owner_mem_d = 1'b0;
                    addr_d      = if_addr_i;
                    wen_d       = 1'b0;
                    wdata_d     = '0;
                    wstrb_d     = '0;
                end
            end
            ST_REQ: begin
                if (bus_req_ready_i) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (bus_rsp_valid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (if_pending && if_flush_i) begin
            drop_d = 1'b1;
        end
        if (state_d == ST_IDLE) begin
            drop_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            owner_mem_q  <= 1'b0;
            drop_q       <= 1'b0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            owner_mem_q  <= owner_mem_d;
            drop_q       <= drop_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention, store, flush, reset, stalls.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid_i;
    logic [63:0] if_addr_i;
    logic        if_flush_i;
    logic        if_req_ready_o;
    logic        if_rsp_valid_o;
    logic [31:0] if_rsp_data_o;
    logic        mem_req_valid_i;
    logic        mem_wen_i;
    logic [63:0] mem_addr_i;
    logic [63:0] mem_wdata_i;
    logic [7:0]  mem_wstrb_i;
    logic        mem_req_ready_o;
    logic        mem_rsp_valid_o;
    logic [63:0] mem_rsp_data_o;
    logic        bus_req_valid_o;
    logic        bus_req_ready_i;
    logic [63:0] bus_addr_o;
    logic        bus_wen_o;
    logic [63:0] bus_wdata_o;
    logic [7:0]  bus_wstrb_o;
    logic        bus_rsp_valid_i;
    logic [63:0] bus_rsp_data_i;
    logic        stall_if_o;
    logic        stall_mem_o;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .if_req_valid_i  (if_req_valid_i),
        .if_addr_i       (if_addr_i),
        .if_flush_i      (if_flush_i),
        .if_req_ready_o  (if_req_ready_o),
        .if_rsp_valid_o  (if_rsp_valid_o),
        .if_rsp_data_o   (if_rsp_data_o),
        .mem_req_valid_i (mem_req_valid_i),
        .mem_wen_i       (mem_wen_i),
        .mem_addr_i      (mem_addr_i),
        .mem_wdata_i     (mem_wdata_i),
        .mem_wstrb_i     (mem_wstrb_i),
        .mem_req_ready_o (mem_req_ready_o),
        .mem_rsp_valid_o (mem_rsp_valid_o),
        .mem_rsp_data_o  (mem_rsp_data_o),
        .bus_req_valid_o (bus_req_valid_o),
        .bus_req_ready_i (bus_req_ready_i),
        .bus_addr_o      (bus_addr_o),
        .bus_wen_o       (bus_wen_o),
        .bus_wdata_o     (bus_wdata_o),
        .bus_wstrb_o     (bus_wstrb_o),
        .bus_rsp_valid_i (bus_rsp_valid_i),
        .bus_rsp_data_i  (bus_rsp_data_i),
        .stall_if_o      (stall_if_o),
        .stall_mem_o     (stall_mem_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow another unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    bit [9:0] grant_pat = 10'b0111101111;

    initial begin
        rst = 1'b1;
        if_req_valid_i = 0; if_addr_i = '0; if_flush_i = 0;
        mem_req_valid_i = 0; mem_wen_i = 0; mem_addr_i = '0; mem_wdata_i = '0; mem_wstrb_i = '0;
        bus_req_ready_i = 0; bus_rsp_valid_i = 0; bus_rsp_data_i = '0;
        tick(); tick();

        // Reset: outputs stay low even with both requesters valid.
        if_req_valid_i = 1; mem_req_valid_i = 1; #1;
        chk("rst_if_ready", if_req_ready_o, 0);
        chk("rst_mem_ready", mem_req_ready_o, 0);
        chk("rst_stall_if", stall_if_o, 0);
        chk("rst_stall_mem", stall_mem_o, 0);
        chk("rst_bus_valid", bus_req_valid_o, 0);
        chk("rst_bus_addr", bus_addr_o, 0);
        tick();
        rst = 0; if_req_valid_i = 0; mem_req_valid_i = 0;

        // Bus response in IDLE is ignored.
        bus_rsp_valid_i = 1; bus_rsp_data_i = 64'h1234; #1;
        chk("idle_rsp_if", if_rsp_valid_o, 0);
        chk("idle_rsp_mem", mem_rsp_valid_o, 0);
        bus_rsp_valid_i = 0;

        // Single fetch at 0x8000_0004 selects the upper word.
        if_req_valid_i = 1; if_addr_i = 64'h8000_0004; #1;
        chk("fetch_ready", if_req_ready_o, 1);
        chk("fetch_mem_ready", mem_req_ready_o, 0);
        chk("fetch_stall_if", stall_if_o, 0);
        tick();
        if_req_valid_i = 0; if_addr_i = 64'hFFFF_FFF0; #1;
        chk("fetch_bus_valid", bus_req_valid_o, 1);
        chk("fetch_bus_addr", bus_addr_o, 64'h8000_0004);
        chk("fetch_bus_wen", bus_wen_o, 0);
        chk("fetch_bus_wstrb", bus_wstrb_o, 0);
        bus_rsp_valid_i = 1; bus_rsp_data_i = 64'h9999; #1;
        chk("fetch_rsp_in_req", if_rsp_valid_o, 0);
        bus_rsp_valid_i = 0;
        tick();
        bus_req_ready_i = 1; #1;
        chk("fetch_bus_valid2", bus_req_valid_o, 1);
        tick();
        bus_req_ready_i = 0; #1;
        chk("fetch_bus_valid_rsp", bus_req_valid_o, 0);
        bus_rsp_valid_i = 1; bus_rsp_data_i = 64'h1111_2222_3333_4444; #1;
        chk("fetch_rsp_valid", if_rsp_valid_o, 1);
        chk("fetch_rsp_data", if_rsp_data_o, 64'h1111_2222);
        chk("fetch_mem_rsp", mem_rsp_valid_o, 0);
        tick();
        bus_rsp_valid_i = 0; if_req_valid_i = 1; if_addr_i = 64'h40; #1;
        chk("fetch_rsp_pulse", if_rsp_valid_o, 0);
        chk("fetch_back_idle", if_req_ready_o, 1);
        if_req_valid_i = 0;

        // Contention: MEM x4 then IF, repeating.
        if_req_valid_i = 1; if_addr_i = 64'h4;
        mem_req_valid_i = 1; mem_wen_i = 0; mem_addr_i = 64'h200;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("cont_mem_ready_%0d", i), mem_req_ready_o, grant_pat[i]);
            chk($sformatf("cont_if_ready_%0d", i), if_req_ready_o, !grant_pat[i]);
            tick();
            bus_req_ready_i = 1; #1;
            chk($sformatf("cont_stall_if_%0d", i), stall_if_o, 1);
            tick();
            bus_req_ready_i = 0; bus_rsp_valid_i = 1; bus_rsp_data_i = 64'h55; #1;
            chk($sformatf("cont_mem_rsp_%0d", i), mem_rsp_valid_o, grant_pat[i]);
            chk($sformatf("cont_if_rsp_%0d", i), if_rsp_valid_o, !grant_pat[i]);
            tick();
            bus_rsp_valid_i = 0;
        end
        if_req_valid_i = 0; mem_req_valid_i = 0;

        // Store held stable while the bus stalls, then accept with a coincident response.
        mem_req_valid_i = 1; mem_wen_i = 1; mem_addr_i = 64'h100;
        mem_wdata_i = 64'hDEAD_BEEF; mem_wstrb_i = 8'h0F; #1;
        chk("st_ready", mem_req_ready_o, 1);
        tick();
        mem_req_valid_i = 0; mem_wen_i = 0; mem_addr_i = 64'hFFFF; mem_wdata_i = '0; mem_wstrb_i = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("st_bus_valid_%0d", c), bus_req_valid_o, 1);
            chk($sformatf("st_bus_addr_%0d", c), bus_addr_o, 64'h100);
            chk($sformatf("st_bus_wen_%0d", c), bus_wen_o, 1);
            chk($sformatf("st_bus_wdata_%0d", c), bus_wdata_o, 64'hDEAD_BEEF);
            chk($sformatf("st_bus_wstrb_%0d", c), bus_wstrb_o, 8'h0F);
            tick();
        end
        bus_req_ready_i = 1; bus_rsp_valid_i = 1; #1;
        chk("st_both_no_rsp", mem_rsp_valid_o, 0);
        tick();
        bus_req_ready_i = 0; bus_rsp_valid_i = 0; #1;
        chk("st_rsp_wait_valid", bus_req_valid_o, 0);
        chk("st_rsp_wait_rsp", mem_rsp_valid_o, 0);
        tick();
        bus_rsp_valid_i = 1; bus_rsp_data_i = 64'hABCD; #1;
        chk("st_ack", mem_rsp_valid_o, 1);
        chk("st_ack_data", mem_rsp_data_o, 64'hABCD);
        chk("st_ack_if", if_rsp_valid_o, 0);
        tick();
        bus_rsp_valid_i = 0; #1;
        chk("st_ack_pulse", mem_rsp_valid_o, 0);

        // Flush gates fetch ready in IDLE.
        if_req_valid_i = 1; if_flush_i = 1; if_addr_i = 64'h1000; #1;
        chk("fl_idle_ready", if_req_ready_o, 0);
        chk("fl_idle_stall", stall_if_o, 1);
        if_flush_i = 0; #1;
        chk("fl_ready", if_req_ready_o, 1);
        tick();
        if_req_valid_i = 0; bus_req_ready_i = 1;
        tick();
        bus_req_ready_i = 0; if_flush_i = 1;
        tick();
        if_flush_i = 0; bus_rsp_valid_i = 1; bus_rsp_data_i = 64'h5555_6666_7777_8888; #1;
        chk("fl_dropped", if_rsp_valid_o, 0);
        tick();
        bus_rsp_valid_i = 0; if_req_valid_i = 1; if_addr_i = 64'h2004; #1;
        chk("fl_new_accept", if_req_ready_o, 1);
        tick();
        if_req_valid_i = 0; bus_req_ready_i = 1;
        tick();
        bus_req_ready_i = 0; bus_rsp_valid_i = 1; bus_rsp_data_i = 64'hAAAA_BBBB_CCCC_DDDD; #1;
        chk("fl_drop_cleared", if_rsp_valid_o, 1);
        chk("fl_hi_word", if_rsp_data_o, 64'hAAAA_BBBB);
        tick();
        bus_rsp_valid_i = 0;

        // Stalls: MEM holds the port for 5 cycles while IF waits.
        mem_req_valid_i = 1; mem_wen_i = 0; mem_addr_i = 64'h300; if_req_valid_i = 1; #1;
        chk("stl_mem_ready", mem_req_ready_o, 1);
        chk("stl_if_c0", stall_if_o, 1);
        chk("stl_mem_c0", stall_mem_o, 0);
        tick();
        mem_req_valid_i = 0; #1;
        chk("stl_if_c1", stall_if_o, 1);
        tick();
        bus_req_ready_i = 1; #1;
        chk("stl_if_c2", stall_if_o, 1);
        tick();
        bus_req_ready_i = 0; #1;
        chk("stl_if_c3", stall_if_o, 1);
        tick();
        bus_rsp_valid_i = 1; bus_rsp_data_i = 64'h77; #1;
        chk("stl_if_c4", stall_if_o, 1);
        chk("stl_mem_rsp", mem_rsp_valid_o, 1);
        tick();
        bus_rsp_valid_i = 0; mem_req_valid_i = 1; mem_addr_i = 64'h308; #1;
        chk("stl_mem_after", stall_mem_o, 0);
        chk("stl_if_waits_again", stall_if_o, 1);
        mem_req_valid_i = 0; #1;
        chk("stl_if_granted", if_req_ready_o, 1);
        chk("stl_if_released", stall_if_o, 0);

        // Reset in RSP; late bus response must be ignored.
        if_addr_i = 64'h500;
        tick();
        if_req_valid_i = 0; bus_req_ready_i = 1;
        tick();
        bus_req_ready_i = 0; rst = 1; if_req_valid_i = 1; mem_req_valid_i = 1; #1;
        chk("rr_if_ready", if_req_ready_o, 0);
        chk("rr_mem_ready", mem_req_ready_o, 0);
        chk("rr_stall_if", stall_if_o, 0);
        chk("rr_stall_mem", stall_mem_o, 0);
        chk("rr_bus_valid", bus_req_valid_o, 0);
        tick();
        rst = 0; if_req_valid_i = 0; mem_req_valid_i = 0; #1;
        chk("rr_bus_addr_clr", bus_addr_o, 0);
        tick();
        bus_rsp_valid_i = 1; bus_rsp_data_i = 64'hFEED; #1;
        chk("rr_late_if_rsp", if_rsp_valid_o, 0);
        chk("rr_late_mem_rsp", mem_rsp_valid_o, 0);
        chk("rr_late_bus_valid", bus_req_valid_o, 0);
        tick();
        bus_rsp_valid_i = 0; mem_req_valid_i = 1; #1;
        chk("rr_still_idle", mem_req_ready_o, 1);
        mem_req_valid_i = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning the address width.
REQ-002 SHALL have parameter DATA_W, default 64, meaning the bus data width.
REQ-003 SHALL have parameter INST_W, default 32, meaning the fetch word width.
REQ-004 SHALL have parameter MAX_STARVE, default 4, meaning the number of consecutive fetch denials before fetch is forced to win.
REQ-005 SHALL have these ports:
  clk  in  1  clock; one clock domain; reset is synchronous and active-high.
  rst  in  1  synchronous active-high reset.
  if_req_valid_i  in  1  fetch request.
  if_addr_i  in  ADDR_W  fetch address.
  if_flush_i  in  1  pipeline flush on a taken branch.
  if_req_ready_o  out  1  fetch request accepted.
  if_rsp_valid_o  out  1  fetch data valid.
  if_rsp_data_o  out  INST_W  instruction.
  mem_req_valid_i  in  1  data request.
  mem_wen_i  in  1  1 for write, 0 for read.
  mem_addr_i  in  ADDR_W  data address.
  mem_wdata_i  in  DATA_W  store data.
  mem_wstrb_i  in  DATA_W/8  byte strobes.
  mem_req_ready_o  out  1  data request accepted.
  mem_rsp_valid_o  out  1  data response valid (read data or write acknowledge).
  mem_rsp_data_o  out  DATA_W  load data.
  bus_req_valid_o  out  1  shared port request.
  bus_req_ready_i  in  1  shared port accepts the request.
  bus_addr_o  out  ADDR_W  shared port address.
  bus_wen_o  out  1  shared port write enable.
  bus_wdata_o  out  DATA_W  shared port write data.
  bus_wstrb_o  out  DATA_W/8  shared port byte strobes.
  bus_rsp_valid_i  in  1  shared port response valid.
  bus_rsp_data_i  in  DATA_W  shared port response data.
  stall_if_o  out  1  stall request to the fetch stage.
  stall_mem_o  out  1  stall request to the memory stage.

Function
REQ-006 SHALL implement a three-state FSM: IDLE, REQ, RSP. At most one transaction is outstanding at any time.
REQ-007 In IDLE, grant SHALL be: MEM if mem_req_valid_i and starve_cnt < MAX_STARVE; otherwise IF if if_req_valid_i; otherwise no grant.
REQ-008 Ready SHALL be combinational and asserted only to the granted requester, only in IDLE. if_req_ready_o SHALL be gated by !if_flush_i.
REQ-009 On acceptance (valid && ready), the block SHALL register addr, wen, wdata, wstrb and owner, and go to REQ the next cycle. IF requests SHALL be forced to wen=0 and wstrb=0.
REQ-010 In REQ, bus_req_valid_o SHALL be 1 and bus_* SHALL hold the registered values stable until bus_req_ready_i. On bus_req_ready_i the FSM SHALL go to RSP.
REQ-011 In RSP, on bus_rsp_valid_i the block SHALL pulse the owner's rsp_valid for exactly that cycle, with data passed combinationally (zero added latency), then return to IDLE.
REQ-012 Fetch data SHALL be bus_rsp_data_i[63:32] if the registered addr[2] is 1, else bus_rsp_data_i[31:0] (for DATA_W=64).
REQ-013 starve_cnt SHALL increment (saturating at MAX_STARVE) each IDLE cycle in which if_req_valid_i is 1 and MEM is granted. It SHALL clear when IF is granted.
REQ-014 If if_flush_i is asserted while an IF-owned transaction is in REQ or RSP, the block SHALL set a drop flag. The transaction completes on the bus, but if_rsp_valid_o is suppressed for its response. The drop flag clears on return to IDLE.
REQ-015 stall_if_o SHALL be 1 when if_req_valid_i is 1 and (IF is not accepted this cycle, or an IF transaction is pending). stall_mem_o SHALL be defined the same way for MEM.
REQ-016 bus_rsp_valid_i in IDLE or REQ SHALL be ignored and produce no rsp_valid.
REQ-017 Simultaneous bus_req_ready_i and bus_rsp_valid_i in REQ SHALL be treated as the bus accepting the request only; the response is expected in a later cycle.
REQ-018 rsp_valid to the non-owner SHALL always be 0.

Reset
REQ-019 On rst=1 at a clock edge, the block SHALL enter IDLE and clear starve_cnt, owner and the drop flag, with all registered bus_* fields set to 0.
REQ-020 During reset, all outputs SHALL be 0: ready, rsp_valid, bus_req_valid_o and stall outputs.
REQ-021 Reset mid-transaction SHALL abandon the transaction, and any later bus response arriving in IDLE SHALL be ignored per REQ-016.

Verification
REQ-022 Single fetch: IF req addr 0x8000_0004, bus ready after 1 cycle, response 0x1111_2222_3333_4444 -> if_rsp_data_o=0x1111_2222 pulsed 1 cycle; FSM back in IDLE the next cycle.
REQ-023 Contention: IF and MEM both valid continuously, MAX_STARVE=4 -> grants MEM,MEM,MEM,MEM,IF, repeating; starve_cnt clears after the IF grant.
REQ-024 Store: MEM wen=1, addr 0x100, wdata 0xDEAD_BEEF, wstrb 0x0F -> bus_* values match and stay stable over 3 cycles of bus_req_ready_i=0; mem_rsp_valid_o pulses on the acknowledge.
REQ-025 Flush: IF transaction in RSP, if_flush_i pulsed -> response consumed with if_rsp_valid_o=0; a new IF request is accepted the cycle after IDLE.
REQ-026 Reset in RSP, bus response arrives 2 cycles later -> no rsp_valid, all outputs 0, FSM stays in IDLE.
REQ-027 Stalls: MEM holds the port for 5 cycles while IF waits -> stall_if_o=1 for all 5 cycles; stall_mem_o=0 after the MEM response.
